// File: rtl/dice_roll_extractor.sv
// Dice roll extractor: gates a ring-oscillator TRNG, debiases its raw bits
// with Von Neumann pairing, rejects out-of-range candidates and presents a
// die face 1..SIDES. A repetition-count health test latches a sticky fault
// when the entropy source appears stuck.
module dice_roll_extractor #(
    parameter int SIDES      = 6,
    parameter int SAMPLE_DIV = 4,
    parameter int WARMUP     = 16,
    parameter int REP_LIMIT  = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       roll_req_i,
    input  logic       random_in_i,
    output logic       osc_en_o,
    output logic       busy_o,
    output logic       roll_valid_o,
    output logic [7:0] roll_value_o,
    output logic       fault_o
);

    localparam int BITS   = $clog2(SIDES);
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int WARM_W = $clog2(WARMUP + 1);
    localparam int CNT_W  = $clog2(BITS + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0]  BITS_C    = CNT_W'(BITS);
    localparam logic [REP_W-1:0]  REP_C     = REP_W'(REP_LIMIT);
    localparam logic [7:0]        SIDES_C   = 8'(SIDES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARM    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_CHECK   = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BITS-1:0]   acc_q, acc_d;
    logic              pair_flag_q, pair_flag_d;
    logic              pair_first_q, pair_first_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              prev_q, prev_d;

    logic              osc_en_q, osc_en_d;
    logic              busy_q, busy_d;
    logic              roll_valid_q, roll_valid_d;
    logic [7:0]        roll_value_q, roll_value_d;
    logic              fault_q, fault_d;

    logic              sample_s;
    logic              yield_s;
    logic              full_s;
    logic              accept_s;
    logic              rep_hit_s;
    logic [REP_W-1:0]  rep_next_s;
    logic [BITS-1:0]   acc_shift_s;
    logic [CNT_W-1:0]  bit_cnt_inc_s;
    logic [DIV_W-1:0]  div_next_s;
    logic [7:0]        acc_ext_s;

    // A raw sample is taken on the last divider count of each window; the
    // second sample of a pair yields its first bit when the two differ.
    assign sample_s      = (state_q == ST_COLLECT) && (div_q == DIV_LAST);
    assign yield_s       = sample_s && pair_flag_q && (pair_first_q != random_in_i);
    assign bit_cnt_inc_s = bit_cnt_q + CNT_W'(1);
    assign full_s        = yield_s && (bit_cnt_inc_s == BITS_C);
    assign div_next_s    = (div_q == DIV_LAST) ? {DIV_W{1'b0}} : (div_q + DIV_W'(1));
    assign acc_ext_s     = 8'(acc_q);
    assign accept_s      = (state_q == ST_CHECK) && (acc_ext_s < SIDES_C);
    assign rep_hit_s     = sample_s && (rep_next_s == REP_C);

    // A one-bit candidate has no history to keep; wider ones shift left.
    generate
        if (BITS == 1) begin : g_acc_one
            assign acc_shift_s = pair_first_q;
        end else begin : g_acc_wide
            assign acc_shift_s = {acc_q[BITS-2:0], pair_first_q};
        end
    endgenerate

    // Repetition count the current sample would produce.
    always_comb begin
        rep_next_s = REP_W'(1);
        if (rep_cnt_q == {REP_W{1'b0}}) begin
            rep_next_s = REP_W'(1);
        end else if (random_in_i == prev_q) begin
            rep_next_s = rep_cnt_q + REP_W'(1);
        end else begin
            rep_next_s = REP_W'(1);
        end
    end

    // Next-state logic of the roll FSM; the health test outranks a full candidate.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (roll_req_i && !fault_q) begin
                    state_d = ST_WARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WARM: begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_WARM;
                end
            end
            ST_COLLECT: begin
                if (rep_hit_s) begin
                    state_d = ST_IDLE;
                end else if (full_s) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter, pairing, accumulator and health-test next values.
    always_comb begin
        warm_cnt_d   = warm_cnt_q;
        div_d        = div_q;
        bit_cnt_d    = bit_cnt_q;
        acc_d        = acc_q;
        pair_flag_d  = pair_flag_q;
        pair_first_d = pair_first_q;
        rep_cnt_d    = rep_cnt_q;
        prev_d       = prev_q;
        case (state_q)
            ST_IDLE: begin
                warm_cnt_d = {WARM_W{1'b0}};
            end
            ST_WARM: begin
                if (warm_cnt_q == WARM_LAST) begin
                    warm_cnt_d  = {WARM_W{1'b0}};
                    div_d       = {DIV_W{1'b0}};
                    bit_cnt_d   = {CNT_W{1'b0}};
                    acc_d       = {BITS{1'b0}};
                    pair_flag_d = 1'b0;
                    rep_cnt_d   = {REP_W{1'b0}};
                end else begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                end
            end
            ST_COLLECT: begin
                div_d = div_next_s;
                if (sample_s) begin
                    prev_d    = random_in_i;
                    rep_cnt_d = rep_next_s;
                    if (pair_flag_q) begin
                        pair_flag_d = 1'b0;
                    end else begin
                        pair_flag_d  = 1'b1;
                        pair_first_d = random_in_i;
                    end
                end else begin
                    prev_d    = prev_q;
                    rep_cnt_d = rep_cnt_q;
                end
                if (yield_s) begin
                    acc_d     = acc_shift_s;
                    bit_cnt_d = bit_cnt_inc_s;
                end else begin
                    acc_d     = acc_q;
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_CHECK: begin
                // Divider, pairing and repetition state run on across a rejection.
                div_d = div_next_s;
                if (accept_s) begin
                    acc_d     = acc_q;
                    bit_cnt_d = bit_cnt_q;
                end else begin
                    acc_d     = {BITS{1'b0}};
                    bit_cnt_d = {CNT_W{1'b0}};
                end
            end
            default: begin
                warm_cnt_d = {WARM_W{1'b0}};
            end
        endcase
    end

    // Output next values, decoded from the FSM transition.
    always_comb begin
        osc_en_d     = (state_d != ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        roll_valid_d = accept_s;
        fault_d      = fault_q | rep_hit_s;
        if (accept_s) begin
            roll_value_d = acc_ext_s + 8'd1;
        end else begin
            roll_value_d = roll_value_q;
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            warm_cnt_q   <= {WARM_W{1'b0}};
            div_q        <= {DIV_W{1'b0}};
            bit_cnt_q    <= {CNT_W{1'b0}};
            acc_q        <= {BITS{1'b0}};
            pair_flag_q  <= 1'b0;
            pair_first_q <= 1'b0;
            rep_cnt_q    <= {REP_W{1'b0}};
            prev_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            warm_cnt_q   <= warm_cnt_d;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            acc_q        <= acc_d;
            pair_flag_q  <= pair_flag_d;
            pair_first_q <= pair_first_d;
            rep_cnt_q    <= rep_cnt_d;
            prev_q       <= prev_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            osc_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            roll_valid_q <= 1'b0;
            roll_value_q <= 8'd0;
            fault_q      <= 1'b0;
        end else begin
            osc_en_q     <= osc_en_d;
            busy_q       <= busy_d;
            roll_valid_q <= roll_valid_d;
            roll_value_q <= roll_value_d;
            fault_q      <= fault_d;
        end
    end

    assign osc_en_o     = osc_en_q;
    assign busy_o       = busy_q;
    assign roll_valid_o = roll_valid_q;
    assign roll_value_o = roll_value_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_dice_roll_extractor.sv
// Directed bench for dice_roll_extractor: default build (SIDES=6) plus a
// SIDES=2 build. Cycle numbers in comments count from the roll_req cycle (0).
module tb_dice_roll_extractor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       roll_req = 1'b0;
    logic       random_in = 1'b0;
    logic       osc_en, busy, roll_valid, fault;
    logic [7:0] roll_value;

    logic       roll_req2 = 1'b0;
    logic       random_in2 = 1'b0;
    logic       osc_en2, busy2, roll_valid2, fault2;
    logic [7:0] roll_value2;

    int n_vec = 0;
    int n_err = 0;
    int vcnt  = 0;
    int vcnt2 = 0;
    int vsave = 0;

    dice_roll_extractor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .roll_req_i   (roll_req),
        .random_in_i  (random_in),
        .osc_en_o     (osc_en),
        .busy_o       (busy),
        .roll_valid_o (roll_valid),
        .roll_value_o (roll_value),
        .fault_o      (fault)
    );

    dice_roll_extractor #(.SIDES(2)) dut2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .roll_req_i   (roll_req2),
        .random_in_i  (random_in2),
        .osc_en_o     (osc_en2),
        .busy_o       (busy2),
        .roll_valid_o (roll_valid2),
        .roll_value_o (roll_value2),
        .fault_o      (fault2)
    );

    always #5 clk = ~clk;

    // Count roll_valid pulses away from the active edge.
    always @(negedge clk) begin
        if (roll_valid === 1'b1) vcnt++;
        if (roll_valid2 === 1'b1) vcnt2++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One raw sample window of SAMPLE_DIV (4) cycles; the sample lands in its last cycle.
    task automatic send(input int which, input logic b);
        if (which == 0) random_in = b;
        else random_in2 = b;
        repeat (4) tick();
    endtask

    // Pulse roll_req for one cycle (cycle 0) and land in cycle 1.
    task automatic start(input int which);
        if (which == 0) roll_req = 1'b1;
        else roll_req2 = 1'b1;
        tick();
        roll_req  = 1'b0;
        roll_req2 = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        repeat (3) tick();
        check("rst_osc_en", osc_en, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", roll_valid, 0);
        check("rst_value", roll_value, 0);
        check("rst_fault", fault, 0);
        check("rst2_busy", busy2, 0);
        reset_n = 1'b1;
        tick();

        // ---- accept path: (1,0),(0,1),(1,0) -> acc=5 -> 6 ----
        start(0);
        check("acc_osc_en_c1", osc_en, 1);
        check("acc_busy_c1", busy, 1);
        repeat (16) tick();                      // cycle 17, first COLLECT cycle
        send(0, 1'b1); send(0, 1'b0);
        send(0, 1'b0); send(0, 1'b1);
        send(0, 1'b1); send(0, 1'b0);            // cycle 41, CHECK
        check("acc_valid_c41", roll_valid, 0);
        check("acc_osc_c41", osc_en, 1);
        vsave = vcnt;
        tick();                                  // cycle 42
        check("acc_valid_c42", roll_valid, 1);
        check("acc_value", roll_value, 6);
        check("acc_busy_c42", busy, 0);
        check("acc_osc_c42", osc_en, 0);
        roll_req = 1'b1;                         // accepted alongside roll_valid
        tick();
        roll_req = 1'b0;
        check("reqvalid_busy", busy, 1);
        check("reqvalid_osc", osc_en, 1);
        check("acc_valid_once", roll_valid, 0);
        check("acc_value_hold", roll_value, 6);
        check("acc_pulses", vcnt - vsave, 1);

        // ---- rejection: bits 1,1,1 (acc=7) then 0,1,0 -> 3 ----
        repeat (16) tick();                      // cycle 17
        send(0, 1'b1); send(0, 1'b0);
        send(0, 1'b1); send(0, 1'b0);
        send(0, 1'b1); send(0, 1'b0);            // cycle 41, CHECK of 7
        vsave = vcnt;
        check("rej_busy_c41", busy, 1);
        send(0, 1'b0);                           // cycle 45
        check("rej_no_valid", vcnt - vsave, 0);
        check("rej_osc_en", osc_en, 1);
        check("rej_busy", busy, 1);
        send(0, 1'b1);
        send(0, 1'b1); send(0, 1'b0);
        send(0, 1'b0); send(0, 1'b1);            // cycle 65, CHECK of 2
        check("rej_valid_c65", roll_valid, 0);
        tick();                                  // cycle 66
        check("rej_valid_c66", roll_valid, 1);
        check("rej_value", roll_value, 3);
        check("rej_busy_end", busy, 0);

        // ---- debias discard: (1,1),(1,0),(0,0),(0,1),(1,1),(1,0) -> 6, +24 cycles ----
        start(0);
        repeat (16) tick();
        send(0, 1'b1); send(0, 1'b1);
        send(0, 1'b1); send(0, 1'b0);
        send(0, 1'b0); send(0, 1'b0);
        send(0, 1'b0); send(0, 1'b1);
        send(0, 1'b1); send(0, 1'b1);
        send(0, 1'b1); send(0, 1'b0);            // cycle 65
        check("dis_valid_c65", roll_valid, 0);
        check("dis_busy_c65", busy, 1);
        tick();                                  // cycle 66
        check("dis_valid_c66", roll_valid, 1);
        check("dis_value", roll_value, 6);

        // ---- busy: roll_req during WARM and COLLECT ignored -> 5 ----
        tick();
        vsave = vcnt;
        start(0);
        repeat (4) tick();                       // cycle 5, WARM
        roll_req = 1'b1;
        tick();
        roll_req = 1'b0;
        check("busy_warm", busy, 1);
        repeat (11) tick();                      // cycle 17, COLLECT
        roll_req = 1'b1;
        random_in = 1'b1;
        tick();
        roll_req = 1'b0;
        repeat (3) tick();                       // cycle 21
        send(0, 1'b0);
        send(0, 1'b0); send(0, 1'b1);
        send(0, 1'b0); send(0, 1'b1);            // cycle 41
        check("busy_valid_c41", roll_valid, 0);
        tick();                                  // cycle 42
        check("busy_valid_c42", roll_valid, 1);
        check("busy_value", roll_value, 5);
        repeat (3) tick();
        check("busy_no_queue", busy, 0);
        check("busy_no_queue_osc", osc_en, 0);
        check("busy_pulses", vcnt - vsave, 1);

        // ---- reset mid-COLLECT, then clean restart -> 3 ----
        vsave = vcnt;
        start(0);
        repeat (16) tick();
        send(0, 1'b1); send(0, 1'b0);            // cycle 25
        check("pre_rst_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_osc", osc_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", roll_valid, 0);
        check("mid_rst_value", roll_value, 0);
        check("mid_rst_fault", fault, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("rst_abort_pulses", vcnt - vsave, 0);
        start(0);
        check("rst_restart_osc", osc_en, 1);
        repeat (16) tick();
        send(0, 1'b0); send(0, 1'b1);
        send(0, 1'b1); send(0, 1'b0);
        send(0, 1'b0); send(0, 1'b1);            // cycle 41
        check("rst_valid_c41", roll_valid, 0);
        tick();                                  // cycle 42
        check("rst_valid_c42", roll_valid, 1);
        check("rst_value_after", roll_value, 3);

        // ---- stuck source: fault at cycle 1 + 16 + 32*4 = 145 ----
        tick();
        vsave = vcnt;
        random_in = 1'b1;
        start(0);                                // cycle 1
        repeat (143) tick();                     // cycle 144
        check("stuck_fault_c144", fault, 0);
        check("stuck_busy_c144", busy, 1);
        tick();                                  // cycle 145
        check("stuck_fault_c145", fault, 1);
        check("stuck_busy_c145", busy, 0);
        check("stuck_osc_c145", osc_en, 0);
        check("stuck_no_valid", vcnt - vsave, 0);
        roll_req = 1'b1;
        tick();
        roll_req = 1'b0;
        check("stuck_req_ignored", busy, 0);
        check("stuck_req_osc", osc_en, 0);
        tick();
        check("stuck_sticky", fault, 1);
        reset_n = 1'b0;
        tick();
        check("stuck_rst_fault", fault, 0);
        reset_n = 1'b1;
        random_in = 1'b0;
        tick();

        // ---- SIDES=2 build: one bit per roll, never rejected ----
        vsave = vcnt2;
        start(1);
        check("s2_busy_c1", busy2, 1);
        repeat (16) tick();
        send(1, 1'b1); send(1, 1'b0);            // cycle 25, CHECK
        check("s2_valid_c25", roll_valid2, 0);
        tick();                                  // cycle 26
        check("s2_valid_c26", roll_valid2, 1);
        check("s2_value_a", roll_value2, 2);
        start(1);                                // accepted alongside roll_valid
        repeat (16) tick();
        send(1, 1'b1); send(1, 1'b1);
        send(1, 1'b0); send(1, 1'b1);            // cycle 33
        check("s2_valid_c33", roll_valid2, 0);
        tick();                                  // cycle 34
        check("s2_valid_c34", roll_valid2, 1);
        check("s2_value_b", roll_value2, 1);
        check("s2_busy_end", busy2, 0);
        tick();
        check("s2_pulses", vcnt2 - vsave, 2);
        check("s2_fault", fault2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
